mem_stage_hs: RTL

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

---
 rtl/mem_stage_hs.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: pipeline memory stage driving a req/ack data-memory port, with load alignment and store lane steering.
// Defining MEM_STAGE_TIMEOUT_EN adds an abort timer on the WAIT state (TIMEOUT_CYC cycles).
module mem_stage_hs #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_signext,
    input  logic [31:0]       ex_mem_regb,
    input  logic [31:0]       ex_mem_wbvalue,
    input  logic              ex_mem_selwsource,
    input  logic [4:0]        ex_mem_regdest,
    input  logic              ex_mem_writereg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic              mem_timeout,
    output logic [4:0]        mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic [31:0]       mem_wb_wbvalue
);
    // state | meaning
    // IDLE  | nothing outstanding; an aligned access is issued combinationally
    // WAIT  | request outstanding, held until mem_ack (or timer abort)
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  regdest_q, regdest_d;
    logic        writereg_q, writereg_d;
    logic [31:0] wbvalue_q, wbvalue_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        access, aligned, complete, timeout_hit;
    logic [1:0]  lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [3:0]  be_st;

    assign access   = ex_mem_readmem | ex_mem_writemem;
    assign lane     = ex_mem_wbvalue[1:0];
    assign aligned  = (ex_mem_size == 2'b00) ||
                      (ex_mem_size == 2'b01 && !lane[0]) ||
                      (ex_mem_size[1] && lane == 2'b00);
    assign mem_addr = ex_mem_wbvalue[ADDR_W+1:2];

    always_comb begin
        byte_v    = mem_rdata[{lane, 3'b000} +: 8];
        half_v    = mem_rdata[{lane[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        mem_wdata = ex_mem_regb;
        be_st     = 4'b1111;
        case (ex_mem_size)
            2'b00: begin
                load_data = {{24{ex_mem_signext & byte_v[7]}}, byte_v};
                mem_wdata = {4{ex_mem_regb[7:0]}};
                be_st     = 4'b0001 << lane;
            end
            2'b01: begin
                load_data = {{16{ex_mem_signext & half_v[15]}}, half_v};
                mem_wdata = {2{ex_mem_regb[15:0]}};
                be_st     = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        mem_be = ex_mem_writemem ? be_st : 4'b1111;
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Ack on the expiry cycle takes precedence over the abort.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == IDLE) begin
            tmo_cnt_d = 8'd0;
        end else if (!mem_ack) begin
            tmo_cnt_d   = tmo_cnt_q + 8'd1;
            timeout_hit = (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tmo_cnt_q <= 8'd0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic [7:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

    // Stall drops on the abort cycle so upstream can move past the dead access.
    always_comb begin
        mem_req   = ((state_q == WAIT) | (access & aligned)) & ~reset;
        mem_we    = mem_req & ex_mem_writemem;
        mem_stall = mem_req & ~mem_ack & ~timeout_hit;
        complete  = mem_req & mem_ack;

        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req && !mem_ack) state_d = WAIT;
            WAIT:    if (mem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        regdest_d  = regdest_q;
        writereg_d = 1'b0;
        wbvalue_d  = wbvalue_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_hit;
        if (state_q == IDLE && access && !aligned) begin
            misalign_d = 1'b1;
        end else if (complete || !access) begin
            regdest_d  = ex_mem_regdest;
            writereg_d = ex_mem_writereg;
            wbvalue_d  = (ex_mem_selwsource & ex_mem_readmem & ~ex_mem_writemem) ?
                         load_data : ex_mem_wbvalue;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            regdest_q  <= 5'd0;
            writereg_q <= 1'b0;
            wbvalue_q  <= 32'd0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            regdest_q  <= regdest_d;
            writereg_q <= writereg_d;
            wbvalue_q  <= wbvalue_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_wb_regdest  = regdest_q;
    assign mem_wb_writereg = writereg_q;
    assign mem_wb_wbvalue  = wbvalue_q;
    assign mem_misalign    = misalign_q;
    assign mem_timeout     = timeout_q;
endmodule
